// File: rtl/renamed_regfile_ckpt_if.sv
// Bundle between the rename/commit front end and the renamed register file.
// master drives issue/commit/read/checkpoint controls; slave returns reads
// and checkpoint allocation status.
interface renamed_regfile_ckpt_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int ROB_W = 4,
    parameter int NCKPT = 4
);
    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(NCKPT);

    logic             rollback;
    logic             issue;
    logic [RW-1:0]    issue_rd;
    logic [ROB_W-1:0] issue_rob_pos;

    logic             commit;
    logic [RW-1:0]    commit_rd;
    logic [XLEN-1:0]  commit_val;
    logic [ROB_W-1:0] commit_rob_pos;

    logic [RW-1:0]    rs1;
    logic [RW-1:0]    rs2;
    logic [XLEN-1:0]  val1;
    logic [XLEN-1:0]  val2;
    logic [ROB_W:0]   rob_id1;
    logic [ROB_W:0]   rob_id2;

    logic             ckpt_req;
    logic [CW-1:0]    ckpt_id;
    logic             ckpt_full;
    logic             ckpt_free;
    logic [NCKPT-1:0] ckpt_free_mask;

    logic             restore;
    logic [CW-1:0]    restore_id;
    logic [NCKPT-1:0] restore_kill_mask;

    modport master (
        output rollback, issue, issue_rd, issue_rob_pos,
        output commit, commit_rd, commit_val, commit_rob_pos,
        output rs1, rs2, ckpt_req, ckpt_free, ckpt_free_mask,
        output restore, restore_id, restore_kill_mask,
        input  val1, val2, rob_id1, rob_id2, ckpt_id, ckpt_full
    );

    modport slave (
        input  rollback, issue, issue_rd, issue_rob_pos,
        input  commit, commit_rd, commit_val, commit_rob_pos,
        input  rs1, rs2, ckpt_req, ckpt_free, ckpt_free_mask,
        input  restore, restore_id, restore_kill_mask,
        output val1, val2, rob_id1, rob_id2, ckpt_id, ckpt_full
    );
endinterface

// File: rtl/renamed_regfile_ckpt.sv
// Renamed architectural register file with rename-table checkpoints.
// Ports: clk, rst (sync, active high), rdy (global enable), bus (slave side
// of renamed_regfile_ckpt_if: issue, commit, 2 read ports, ckpt/restore).
module renamed_regfile_ckpt #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int ROB_W = 4,
    parameter int NCKPT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    renamed_regfile_ckpt_if.slave bus
);
    localparam int CW = $clog2(NCKPT);

    typedef logic [ROB_W:0] tag_t;

    logic [XLEN-1:0]  val_q [NREG];
    tag_t             tag_q [NREG];
    tag_t             tag_nx [NREG];
    tag_t             ck_q [NCKPT][NREG];
    logic [NCKPT-1:0] vld_q;
    logic [NCKPT-1:0] vld_nx;
    logic [CW-1:0]    free_id;
    tag_t             ctag;
    logic             cmt_wr;
    logic             true_cmt;
    logic             alloc;

    assign ctag     = {1'b1, bus.commit_rob_pos};
    assign cmt_wr   = bus.commit && (bus.commit_rd != '0);
    // A commit only retires the rename if the ROB entry is still the
    // youngest writer of that register.
    assign true_cmt = cmt_wr && (tag_q[bus.commit_rd] == ctag);
    assign alloc    = bus.ckpt_req && !bus.ckpt_full
                      && !bus.rollback && !bus.restore;

    always_comb begin
        free_id = '0;
        for (int i = NCKPT - 1; i >= 0; i--) begin
            if (!vld_q[i]) free_id = CW'(i);
        end
    end

    assign bus.ckpt_id   = free_id;
    assign bus.ckpt_full = &vld_q;

    always_comb begin
        bus.val1    = val_q[bus.rs1];
        bus.rob_id1 = tag_q[bus.rs1];
        bus.val2    = val_q[bus.rs2];
        bus.rob_id2 = tag_q[bus.rs2];
        if (true_cmt && bus.rs1 == bus.commit_rd) begin
            bus.val1    = bus.commit_val;
            bus.rob_id1 = '0;
        end
        if (true_cmt && bus.rs2 == bus.commit_rd) begin
            bus.val2    = bus.commit_val;
            bus.rob_id2 = '0;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) tag_nx[r] = tag_q[r];
        if (bus.rollback) begin
            for (int r = 0; r < NREG; r++) tag_nx[r] = '0;
        end else if (bus.restore) begin
            for (int r = 0; r < NREG; r++) begin
                tag_nx[r] = ck_q[bus.restore_id][r];
            end
            if (true_cmt && tag_nx[bus.commit_rd] == ctag) begin
                tag_nx[bus.commit_rd] = '0;
            end
        end else begin
            if (true_cmt) tag_nx[bus.commit_rd] = '0;
            // Issue lands after the clear so a same-cycle rename wins.
            if (bus.issue && bus.issue_rd != '0) begin
                tag_nx[bus.issue_rd] = {1'b1, bus.issue_rob_pos};
            end
        end
    end

    always_comb begin
        vld_nx = vld_q;
        if (bus.rollback) begin
            vld_nx = '0;
        end else if (bus.restore) begin
            vld_nx = vld_q & ~bus.restore_kill_mask;
        end else begin
            if (bus.ckpt_free) vld_nx = vld_nx & ~bus.ckpt_free_mask;
            if (alloc) vld_nx[free_id] = 1'b1;
        end
    end

    // Checkpoint payloads are not reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end
            vld_q <= '0;
        end else if (rdy) begin
            if (cmt_wr) val_q[bus.commit_rd] <= bus.commit_val;
            for (int r = 0; r < NREG; r++) tag_q[r] <= tag_nx[r];
            vld_q <= vld_nx;
            for (int i = 0; i < NCKPT; i++) begin
                if (vld_q[i] && true_cmt
                    && ck_q[i][bus.commit_rd] == ctag) begin
                    ck_q[i][bus.commit_rd] <= '0;
                end
            end
            // The new slot is invalid, so the clear loop never touches it.
            if (alloc) begin
                for (int r = 0; r < NREG; r++) begin
                    ck_q[free_id][r] <= tag_nx[r];
                end
            end
        end
    end
endmodule

// File: tb/tb_renamed_regfile_ckpt.sv
// Directed bench for renamed_regfile_ckpt: rename, commit bypass,
// checkpoint alloc/free/restore, rollback, rdy hold and reset.
module tb_renamed_regfile_ckpt;
    logic clk;
    logic rst;
    logic rdy;
    int   n_vec;
    int   n_bad;

    renamed_regfile_ckpt_if #(
        .XLEN(32), .NREG(32), .ROB_W(4), .NCKPT(4)
    ) bus ();

    renamed_regfile_ckpt #(
        .XLEN(32), .NREG(32), .ROB_W(4), .NCKPT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, need finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.rollback          = 1'b0;
        bus.issue             = 1'b0;
        bus.issue_rd          = '0;
        bus.issue_rob_pos     = '0;
        bus.commit            = 1'b0;
        bus.commit_rd         = '0;
        bus.commit_val        = '0;
        bus.commit_rob_pos    = '0;
        bus.ckpt_req          = 1'b0;
        bus.ckpt_free         = 1'b0;
        bus.ckpt_free_mask    = '0;
        bus.restore           = 1'b0;
        bus.restore_id        = '0;
        bus.restore_kill_mask = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] pos);
        bus.issue         = 1'b1;
        bus.issue_rd      = rd;
        bus.issue_rob_pos = pos;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] pos,
                             input logic [31:0] v);
        bus.commit         = 1'b1;
        bus.commit_rd      = rd;
        bus.commit_rob_pos = pos;
        bus.commit_val     = v;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle();
        bus.rs1 = 5'd5;
        bus.rs2 = 5'd31;

        // reset wins over rdy low and a pending issue
        rst = 1'b1;
        rdy = 1'b0;
        do_issue(5'd5, 4'd3);
        tick();
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        #1;
        chk("rst_ckpt_id", 32'(bus.ckpt_id), 32'd0);
        chk("rst_full", 32'(bus.ckpt_full), 32'd0);
        chk("rst_val1", bus.val1, 32'd0);
        chk("rst_rob1", 32'(bus.rob_id1), 32'd0);
        chk("rst_rob2", 32'(bus.rob_id2), 32'd0);

        // rename then commit bypass on the read port
        do_issue(5'd5, 4'd3);
        tick();
        #1;
        chk("ren_rob1", 32'(bus.rob_id1), 32'h13);
        do_commit(5'd5, 4'd3, 32'hAB);
        #1;
        chk("byp_val1", bus.val1, 32'hAB);
        chk("byp_rob1", 32'(bus.rob_id1), 32'd0);
        tick();
        #1;
        chk("cmt_val1", bus.val1, 32'hAB);
        chk("cmt_rob1", 32'(bus.rob_id1), 32'd0);

        // same-cycle issue is not visible until the next cycle
        bus.rs2 = 5'd6;
        do_issue(5'd6, 4'd2);
        #1;
        chk("nobyp_rob2", 32'(bus.rob_id2), 32'd0);
        tick();
        #1;
        chk("iss_rob2", 32'(bus.rob_id2), 32'h12);

        // stale commit writes value but keeps the newer rename
        do_issue(5'd5, 4'd3);
        tick();
        do_issue(5'd5, 4'd7);
        tick();
        do_commit(5'd5, 4'd3, 32'd9);
        #1;
        chk("stale_byp_val1", bus.val1, 32'hAB);
        chk("stale_byp_rob1", 32'(bus.rob_id1), 32'h17);
        tick();
        #1;
        chk("stale_val1", bus.val1, 32'd9);
        chk("stale_rob1", 32'(bus.rob_id1), 32'h17);

        bus.rollback = 1'b1;
        tick();

        // checkpoint then restore; issue and ckpt_req ignored on restore
        bus.rs1 = 5'd2;
        bus.rs2 = 5'd3;
        do_issue(5'd2, 4'd1);
        tick();
        bus.ckpt_req = 1'b1;
        #1;
        chk("ck_id0", 32'(bus.ckpt_id), 32'd0);
        tick();
        #1;
        chk("ck_id1", 32'(bus.ckpt_id), 32'd1);
        do_issue(5'd2, 4'd4);
        tick();
        #1;
        chk("pre_rst_rob1", 32'(bus.rob_id1), 32'h14);
        bus.restore           = 1'b1;
        bus.restore_id        = 2'd0;
        bus.restore_kill_mask = 4'b0001;
        bus.ckpt_req          = 1'b1;
        do_issue(5'd3, 4'd5);
        tick();
        #1;
        chk("rsto_rob1", 32'(bus.rob_id1), 32'h11);
        chk("rsto_rob2", 32'(bus.rob_id2), 32'd0);
        chk("rsto_ck_id", 32'(bus.ckpt_id), 32'd0);
        chk("rsto_full", 32'(bus.ckpt_full), 32'd0);

        // commit clears the busy tag inside a live checkpoint
        bus.ckpt_req = 1'b1;
        tick();
        do_commit(5'd2, 4'd1, 32'd7);
        tick();
        do_issue(5'd2, 4'd9);
        tick();
        #1;
        chk("ckc_rob1", 32'(bus.rob_id1), 32'h19);
        chk("ckc_val1", bus.val1, 32'd7);
        bus.restore           = 1'b1;
        bus.restore_id        = 2'd0;
        bus.restore_kill_mask = 4'b0001;
        tick();
        #1;
        chk("ckc_rsto_rob1", 32'(bus.rob_id1), 32'd0);
        chk("ckc_rsto_val1", bus.val1, 32'd7);

        // fill all checkpoints, extra request ignored, free one
        bus.rollback = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fill_id%0d", i), 32'(bus.ckpt_id), 32'(i));
            bus.ckpt_req = 1'b1;
            tick();
        end
        #1;
        chk("full_flag", 32'(bus.ckpt_full), 32'd1);
        chk("full_id", 32'(bus.ckpt_id), 32'd0);
        bus.ckpt_req = 1'b1;
        tick();
        #1;
        chk("full_extra", 32'(bus.ckpt_full), 32'd1);
        bus.ckpt_free      = 1'b1;
        bus.ckpt_free_mask = 4'b0100;
        tick();
        #1;
        chk("free_full", 32'(bus.ckpt_full), 32'd0);
        chk("free_id", 32'(bus.ckpt_id), 32'd2);

        // register 0 is never renamed or written
        bus.rollback = 1'b1;
        tick();
        bus.rs1 = 5'd0;
        do_issue(5'd0, 4'd5);
        do_commit(5'd0, 4'd5, 32'h55);
        #1;
        chk("x0_val_now", bus.val1, 32'd0);
        tick();
        #1;
        chk("x0_val", bus.val1, 32'd0);
        chk("x0_rob", 32'(bus.rob_id1), 32'd0);

        // rdy low holds every piece of state
        bus.rs1 = 5'd7;
        rdy = 1'b0;
        do_issue(5'd7, 4'd2);
        do_commit(5'd7, 4'd0, 32'd3);
        bus.ckpt_req = 1'b1;
        tick();
        rdy = 1'b1;
        #1;
        chk("hold_rob1", 32'(bus.rob_id1), 32'd0);
        chk("hold_val1", bus.val1, 32'd0);
        chk("hold_ck_id", 32'(bus.ckpt_id), 32'd0);

        // rollback beats restore; commit value still lands
        do_issue(5'd7, 4'd2);
        tick();
        bus.ckpt_req = 1'b1;
        tick();
        bus.ckpt_req = 1'b1;
        tick();
        #1;
        chk("pre_rb_id", 32'(bus.ckpt_id), 32'd2);
        chk("pre_rb_rob1", 32'(bus.rob_id1), 32'h12);
        bus.rollback   = 1'b1;
        bus.restore    = 1'b1;
        bus.restore_id = 2'd0;
        do_commit(5'd8, 4'd0, 32'h77);
        tick();
        bus.rs2 = 5'd8;
        #1;
        chk("rb_rob1", 32'(bus.rob_id1), 32'd0);
        chk("rb_ck_id", 32'(bus.ckpt_id), 32'd0);
        chk("rb_full", 32'(bus.ckpt_full), 32'd0);
        chk("rb_val2", bus.val2, 32'h77);

        // reset clears stored values
        bus.rs1 = 5'd2;
        rst = 1'b1;
        rdy = 1'b0;
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        #1;
        chk("rst2_val1", bus.val1, 32'd0);
        chk("rst2_val2", bus.val2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/renamed_regfile_ckpt.md
RENAMED_REGFILE_CKPT -- requirements
Module: renamed_regfile_ckpt

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 SHALL have parameter NREG, default 32, meaning architectural register count (power of 2); RW = log2(NREG).
REQ-003 SHALL have parameter ROB_W, default 4, meaning ROB index width.
REQ-004 SHALL have parameter NCKPT, default 4, meaning rename-table checkpoint count (power of 2, 2..8); CW = log2(NCKPT).
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset; rdy in 1 global enable.
REQ-006 SHALL have ports: rollback in 1 full flush; issue in 1; issue_rd in RW; issue_rob_pos in ROB_W.
REQ-007 SHALL have ports: commit in 1; commit_rd in RW; commit_val in XLEN; commit_rob_pos in ROB_W.
REQ-008 SHALL have ports: rs1/rs2 in RW; val1/val2 out XLEN; rob_id1/rob_id2 out ROB_W+1 ({busy, rob_pos}).
REQ-009 SHALL have ports: ckpt_req in 1; ckpt_id out CW; ckpt_full out 1; ckpt_free in 1; ckpt_free_mask in NCKPT.
REQ-010 SHALL have ports: restore in 1; restore_id in CW; restore_kill_mask in NCKPT.

Function
REQ-011 SHALL hold val[NREG] (XLEN) and tag[NREG] ({busy, rob_pos}); register 0 always reads val 0, tag 0, and is never written or renamed.
REQ-012 SHALL drive read ports combinationally: if commit && commit_rd!=0 && rsX==commit_rd && tag[rsX]=={1,commit_rob_pos}, output val=commit_val, rob_id=0; otherwise output stored val/tag.
REQ-013 SHALL NOT bypass a same-cycle issue to the read ports; reads reflect pre-issue state.
REQ-014 SHALL, on commit with commit_rd!=0, write val[commit_rd]=commit_val unconditionally and clear tag[commit_rd] only on a tag match (true commit).
REQ-015 SHALL, on issue with issue_rd!=0, set tag[issue_rd]={1,issue_rob_pos}; same-cycle issue to commit_rd overrides the commit tag clear.
REQ-016 SHALL keep NCKPT snapshot tables of tag[] plus a valid bitmap; ckpt_id = lowest invalid index (0 when full); ckpt_full = all valid.
REQ-017 SHALL, on ckpt_req && !ckpt_full, mark ckpt_id valid and store the tag table as updated by that cycle's commit and issue; ckpt_req while ckpt_full is ignored.
REQ-018 SHALL, on every true commit, also clear the matching busy tag (same rd, same rob_pos) in every valid checkpoint.
REQ-019 SHALL, on ckpt_free, invalidate every checkpoint whose bit is set in ckpt_free_mask.
REQ-020 SHALL, on restore, load tag[] from checkpoint restore_id, then apply that cycle's true-commit clear; issue and ckpt_req in the same cycle are ignored; checkpoints in restore_kill_mask are invalidated; val[] is unaffected except by commit.
REQ-021 SHALL, on rollback, clear all tags and invalidate all checkpoints; val[] still takes the same-cycle commit write.
REQ-022 SHALL apply precedence rollback > restore > {issue, ckpt_req, ckpt_free}; commit val write applies in every case.
REQ-023 SHALL, with rdy low, hold all state; combinational outputs remain valid.
REQ-024 SHALL have single-cycle latency: updates visible on read ports the cycle after the edge.

Reset
REQ-025 SHALL, on rst at posedge clk, clear all val to 0, all tags to 0, all checkpoint valid bits; then ckpt_id=0, ckpt_full=0, rob_id1/2=0, val1/2=0 for any rs; rst overrides rdy and all other inputs.

Verification
REQ-026 SHALL cover: issue rd=5 rob 3; next cycle rs1=5 -> rob_id1=5'b10011; commit rd=5 rob 3 val 0xAB same cycle as read -> val1=0xAB, rob_id1=0.
REQ-027 SHALL cover: issue rd=5 rob 3, then issue rd=5 rob 7, then commit rd=5 rob 3 val 9 -> val[5]=9, tag stays 5'b10111.
REQ-028 SHALL cover: issue rd=2 rob 1; ckpt_req (ckpt_id=0); issue rd=2 rob 4; restore id 0, kill mask 0001 -> rs1=2 gives rob_id 5'b10001, ckpt 0 invalid, ckpt_id=0.
REQ-029 SHALL cover: checkpoint holds rd=2 busy rob 1; commit rd=2 rob 1 val 7; restore it -> rob_id=0, val=7.
REQ-030 SHALL cover: NCKPT ckpt_req -> ckpt_full=1, extra req ignored; ckpt_free mask 0100 -> ckpt_full=0, ckpt_id=2.
REQ-031 SHALL cover: issue rd=0 -> rs1=0 reads 0/0; rdy low with issue -> no change; rollback with restore -> all tags 0, all checkpoints invalid.
